io_port_bank: RTL and testbench

- Parametrised replacement for the single in-port and out-port registers on the CPU bus.
- Provides N_CH input channels, each buffered by a show-ahead FIFO with a valid/ready handshake toward external devices.
- Provides N_CH output channels, each a holding register with a valid/ack handshake.
- Includes a status word and a wait signal so the control unit can poll or stall instead of reading stale data.

---
 rtl/io_bank_pkg.sv | 32 +++
 rtl/io_fifo.sv | 62 ++++++
 rtl/io_port_bank.sv | 139 +++++++++++++
 tb/tb_io_port_bank.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/io_bank_pkg.sv
// Shared helpers for the I/O port bank: status-word layout, parameter legality
// and channel slicing of the flat device buses.
package io_bank_pkg;

    function automatic int unsigned ne_lsb();
        return 0;
    endfunction

    function automatic int unsigned ov_lsb(input int unsigned n_ch);
        return n_ch;
    endfunction

    function automatic int unsigned rderr_bit(input int unsigned n_ch);
        return 2 * n_ch;
    endfunction

    function automatic int unsigned wrerr_bit(input int unsigned n_ch);
        return 2 * n_ch + 1;
    endfunction

    function automatic bit params_ok(input int unsigned data_w, input int unsigned n_ch,
                                     input int unsigned depth);
        return (n_ch >= 1) && (n_ch <= 15) && (2 * n_ch + 2 <= data_w) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // LSB of channel k inside a flat N_CH*DATA_W bus
    function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Single-channel synchronous show-ahead FIFO; rdata is the head with zero latency.
module io_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_en, pop_en;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_comb begin
        wr_ptr_d = push_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_en && !pop_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_en && !push_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/io_port_bank.sv
// Bank of N_CH buffered input channels and N_CH output holding registers on the CPU bus,
// with a pollable status word and a wait signal for reads of empty channels.
module io_port_bank
    import io_bank_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [DATA_W-1:0]      BusMuxOut,
    input  logic [SEL_W-1:0]       ch_sel,
    input  logic                   in_port_out,
    input  logic                   out_port_enable,
    input  logic                   status_out,
    output logic [DATA_W-1:0]      bus_data,
    output logic                   io_wait,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ack
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    if (!params_ok(DATA_W, N_CH, FIFO_DEPTH)) begin : g_param_check
        $error("io_port_bank: illegal DATA_W/N_CH/FIFO_DEPTH combination");
    end

    logic [DATA_W-1:0] head [N_CH];
    logic [CNT_W-1:0]  cnt [N_CH];
    logic [N_CH-1:0]   full, empty, pop;
    logic [N_CH-1:0]   sel_hot, wr_hot;
    logic              sel_ok, sel_empty, rd_act;
    logic [DATA_W-1:0] sel_head, status_word;
    logic              rd_err_set, wr_err_set;

    logic [DATA_W-1:0] out_data_q [N_CH];
    logic [DATA_W-1:0] out_data_d [N_CH];
    logic [N_CH-1:0]   out_valid_q, out_valid_d;
    logic              rd_err_q, rd_err_d, wr_err_q, wr_err_d;

    // Decode ch_sel one-hot; codes >= N_CH select nothing
    always_comb begin
        sel_hot   = '0;
        sel_head  = '0;
        sel_empty = 1'b0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (32'(ch_sel) == 32'(k)) begin
                sel_hot[k] = 1'b1;
                sel_head   = head[k];
                sel_empty  = empty[k];
            end
        end
        sel_ok = |sel_hot;
    end

    assign rd_act  = in_port_out && !status_out;
    assign pop     = {N_CH{rd_act}} & sel_hot;
    assign io_wait = rd_act && sel_ok && sel_empty;
    assign wr_hot  = {N_CH{out_port_enable}} & sel_hot;

    for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
        io_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clock (clock),
            .clear (clear),
            .push  (in_valid[k]),
            .pop   (pop[k]),
            .wdata (in_data[ch_lsb(k, DATA_W) +: DATA_W]),
            .rdata (head[k]),
            .count (cnt[k]),
            .full  (full[k]),
            .empty (empty[k])
        );

        assign in_ready[k]                           = clear && !full[k];
        assign out_data[ch_lsb(k, DATA_W) +: DATA_W] = out_data_q[k];
    end

    assign out_valid = out_valid_q;

    always_comb begin
        status_word = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            status_word[ne_lsb() + k]      = (cnt[k] != '0);
            status_word[ov_lsb(N_CH) + k] = out_valid_q[k];
        end
        status_word[rderr_bit(N_CH)] = rd_err_q;
        status_word[wrerr_bit(N_CH)] = wr_err_q;
    end

    always_comb begin
        bus_data = '0;
        if (status_out) begin
            bus_data = status_word;
        end else if (in_port_out && sel_ok && !sel_empty) begin
            bus_data = sel_head;
        end
    end

    // A write landing in the same cycle as its ack is a clean handover, not an overwrite
    assign rd_err_set = in_port_out && !sel_ok;
    assign wr_err_set = out_port_enable && (!sel_ok || |(sel_hot & out_valid_q & ~out_ack));

    always_comb begin
        out_valid_d = wr_hot | (out_valid_q & ~out_ack);
        for (int k = 0; k < int'(N_CH); k++) begin
            out_data_d[k] = wr_hot[k] ? BusMuxOut : out_data_q[k];
        end
        rd_err_d = rd_err_set || (rd_err_q && !status_out);
        wr_err_d = wr_err_set || (wr_err_q && !status_out);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int k = 0; k < int'(N_CH); k++) begin
                out_data_q[k] <= '0;
            end
            out_valid_q <= '0;
            rd_err_q    <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            for (int k = 0; k < int'(N_CH); k++) begin
                out_data_q[k] <= out_data_d[k];
            end
            out_valid_q <= out_valid_d;
            rd_err_q    <= rd_err_d;
            wr_err_q    <= wr_err_d;
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank: FIFO fill/drain, io_wait, output overwrite errors,
// ack/write handover and asynchronous reset.
module tb_io_port_bank;

    localparam int unsigned DW = 32;
    localparam int unsigned N  = 4;

    logic            clock = 1'b0;
    logic            clear;
    logic [DW-1:0]   BusMuxOut;
    logic [1:0]      ch_sel;
    logic            in_port_out;
    logic            out_port_enable;
    logic            status_out;
    logic [DW-1:0]   bus_data;
    logic            io_wait;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ack;

    int tests = 0;
    int fails = 0;

    io_port_bank #(
        .DATA_W     (DW),
        .N_CH       (N),
        .FIFO_DEPTH (8)
    ) dut (
        .clock           (clock),
        .clear           (clear),
        .BusMuxOut       (BusMuxOut),
        .ch_sel          (ch_sel),
        .in_port_out     (in_port_out),
        .out_port_enable (out_port_enable),
        .status_out      (status_out),
        .bus_data        (bus_data),
        .io_wait         (io_wait),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ack         (out_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear           = 1'b0;
        BusMuxOut       = '0;
        ch_sel          = '0;
        in_port_out     = 1'b0;
        out_port_enable = 1'b0;
        status_out      = 1'b0;
        in_data         = '0;
        in_valid        = '0;
        out_ack         = '0;

        #2;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        #6 clear = 1'b1;
        tick();

        // Idle after reset
        check("idle_in_ready", 32'(in_ready), 32'hF);
        check("idle_out_valid", 32'(out_valid), 32'h0);
        check("idle_bus", bus_data, 32'h0);
        check("idle_wait", 32'(io_wait), 32'h0);
        status_out = 1'b1;
        #1 check("idle_status", bus_data, 32'h0);
        status_out = 1'b0;

        // Fill ch2 with eight words
        for (int i = 0; i < 8; i++) begin
            in_valid[2]     = 1'b1;
            in_data[64 +: DW] = 32'hA5A5_0001 + i;
            tick();
        end
        in_data[64 +: DW] = 32'h0000_0BAD;
        #1 check("full_ready", 32'(in_ready), 32'hB);
        tick();
        in_valid = '0;
        status_out = 1'b1;
        #1 check("full_status", bus_data, 32'h0000_0004);
        status_out = 1'b0;

        // Drain ch2 in order
        in_port_out = 1'b1;
        ch_sel      = 2'd2;
        for (int i = 0; i < 8; i++) begin
            #1 check("drain_word", bus_data, 32'hA5A5_0001 + i);
            tick();
        end
        #1 check("drain_empty_wait", 32'(io_wait), 32'h1);
        check("drain_empty_bus", bus_data, 32'h0);
        in_port_out = 1'b0;
        check("drain_ready", 32'(in_ready), 32'hF);

        // Read of empty ch1 with a same-cycle push
        in_port_out       = 1'b1;
        ch_sel            = 2'd1;
        in_valid[1]       = 1'b1;
        in_data[32 +: DW] = 32'h0000_1234;
        #1 check("empty_wait", 32'(io_wait), 32'h1);
        check("empty_bus", bus_data, 32'h0);
        tick();
        in_valid = '0;
        #1 check("push_wait", 32'(io_wait), 32'h0);
        check("push_bus", bus_data, 32'h0000_1234);
        tick();
        #1 check("popped_wait", 32'(io_wait), 32'h1);
        in_port_out = 1'b0;
        status_out  = 1'b1;
        #1 check("popped_status", bus_data, 32'h0);
        status_out = 1'b0;

        // Overwrite on ch3 raises wr_err
        out_port_enable = 1'b1;
        ch_sel          = 2'd3;
        BusMuxOut       = 32'hDEAD_BEEF;
        tick();
        BusMuxOut = 32'h0000_0001;
        tick();
        out_port_enable = 1'b0;
        #1 check("ow_data", out_data[96 +: DW], 32'h0000_0001);
        check("ow_valid", 32'(out_valid), 32'h8);
        status_out = 1'b1;
        #1 check("ow_status1", bus_data, 32'h0000_0280);
        tick();
        #1 check("ow_status2", bus_data, 32'h0000_0080);
        status_out = 1'b0;

        // Same-cycle ack and write on ch0
        out_port_enable = 1'b1;
        ch_sel          = 2'd0;
        BusMuxOut       = 32'h0000_0011;
        tick();
        BusMuxOut  = 32'h0000_0022;
        out_ack[0] = 1'b1;
        tick();
        out_port_enable = 1'b0;
        out_ack         = '0;
        #1 check("handover_valid", 32'(out_valid), 32'h9);
        check("handover_data", out_data[0 +: DW], 32'h0000_0022);
        status_out = 1'b1;
        #1 check("handover_status", bus_data, 32'h0000_0090);
        status_out = 1'b0;
        out_ack    = 4'b0011;
        tick();
        out_ack = '0;
        #1 check("ack_valid", 32'(out_valid), 32'h8);

        // Build state, then check status priority over a pop
        out_port_enable = 1'b1;
        ch_sel          = 2'd1;
        BusMuxOut       = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            in_valid[0]      = 1'b1;
            in_data[0 +: DW] = 32'h0000_00C0 + i;
            tick();
            out_port_enable = 1'b0;
        end
        in_valid    = '0;
        status_out  = 1'b1;
        in_port_out = 1'b1;
        ch_sel      = 2'd0;
        #1 check("prio_status", bus_data, 32'h0000_00A1);
        tick();
        status_out = 1'b0;
        #1 check("prio_no_pop", bus_data, 32'h0000_00C0);
        in_port_out = 1'b0;

        // Asynchronous reset mid-stream
        clear = 1'b0;
        #1 check("arst_valid", 32'(out_valid), 32'h0);
        check("arst_data1", out_data[32 +: DW], 32'h0);
        check("arst_ready", 32'(in_ready), 32'h0);
        status_out = 1'b1;
        #1 check("arst_status", bus_data, 32'h0);
        status_out = 1'b0;
        clear      = 1'b1;
        tick();
        in_port_out = 1'b1;
        ch_sel      = 2'd0;
        #1 check("post_rst_wait", 32'(io_wait), 32'h1);
        check("post_rst_ready", 32'(in_ready), 32'hF);
        in_port_out = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
